spike_line_serializer: RTL and testbench

SPIKE_LINE_SERIALIZER -- requirements
Module: spike_line_serializer

---
 rtl/spike_line_serializer_pkg.sv | 24 ++
 rtl/spike_line_serializer_if.sv | 28 ++
 rtl/spike_line_serializer_pixel_mux.sv | 31 +++
 rtl/spike_line_serializer.sv | 100 ++++++++++
 tb/tb_spike_line_serializer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/spike_line_serializer_pkg.sv
// Shared hyper-parameters, FSM encoding and pixel-count helper for the
// spike line serializer.
package spike_line_serializer_pkg;

    localparam int TIME_STEPS = 4;
    localparam int IMG_WIDTH  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Real pixels per line, clamped so a malformed size never yields 0 beats
    // or indexes beyond the line word.
    function automatic logic [15:0] clamp_pixels(input logic [15:0] size,
                                                 input int          width);
        if (size < 16'd3)
            return 16'd1;
        if ((size - 16'd2) > 16'(width))
            return 16'(width);
        return size - 16'd2;
    endfunction

endpackage

// File: rtl/spike_line_serializer_if.sv
// Line-word input and pixel-stream output of the spike line serializer.
interface spike_line_serializer_if #(
    parameter int TIME_STEPS = spike_line_serializer_pkg::TIME_STEPS,
    parameter int IMG_WIDTH  = spike_line_serializer_pkg::IMG_WIDTH
);
    logic                            code_valid;
    logic [15:0]                     conv_img_size;
    logic [IMG_WIDTH*TIME_STEPS-1:0] i_line_data;
    logic                            i_line_data_valid;
    logic                            o_line_ready;
    logic [TIME_STEPS-1:0]           o_spikes_out;
    logic                            o_spikes_out_valid;
    logic                            i_spikes_out_ready;
    logic                            o_line_done;

    modport master (
        output code_valid, conv_img_size, i_line_data, i_line_data_valid,
               i_spikes_out_ready,
        input  o_line_ready, o_spikes_out, o_spikes_out_valid, o_line_done
    );

    modport slave (
        input  code_valid, conv_img_size, i_line_data, i_line_data_valid,
               i_spikes_out_ready,
        output o_line_ready, o_spikes_out, o_spikes_out_valid, o_line_done
    );

endinterface

// File: rtl/spike_line_serializer_pixel_mux.sv
// Beat-to-pixel selector: maps a beat index onto a pixel of the line word,
// producing zeros for the leading/trailing pad beats.
module spike_pixel_mux
    import spike_line_serializer_pkg::*;
#(
    parameter int TIME_STEPS = spike_line_serializer_pkg::TIME_STEPS,
    parameter int IMG_WIDTH  = spike_line_serializer_pkg::IMG_WIDTH,
    parameter int PAD        = 0
) (
    input  logic [IMG_WIDTH*TIME_STEPS-1:0] line_data,
    input  logic [15:0]                     beat_idx,
    input  logic [15:0]                     pix_count,
    output logic [TIME_STEPS-1:0]           spikes
);

    logic [15:0] pix_idx;
    logic        in_line;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        spikes  = '0;
        pix_idx = beat_idx - 16'(PAD);
        in_line = (beat_idx >= 16'(PAD)) && (beat_idx < (pix_count + 16'(PAD)));
        for (int k = 0; k < IMG_WIDTH; k++) begin
            if (in_line && (pix_idx == 16'(k)))
                spikes = line_data[k*TIME_STEPS +: TIME_STEPS];
        end
    end

endmodule

// File: rtl/spike_line_serializer.sv
// Serializes one packed line word into a stream of per-pixel spike vectors,
// optionally framed by zero pad pixels, with a done pulse per line.
module spike_line_serializer
    import spike_line_serializer_pkg::*;
#(
    parameter int TIME_STEPS = spike_line_serializer_pkg::TIME_STEPS,
    parameter int IMG_WIDTH  = spike_line_serializer_pkg::IMG_WIDTH,
    parameter int PAD        = 0
) (
    input  logic                    s_clk,
    input  logic                    s_rst,
    spike_line_serializer_if.slave  bus
);

    state_t                          state_q, state_d;
    logic [15:0]                     beat_q, beat_d;
    logic [15:0]                     pix_q, pix_d;
    logic [15:0]                     size_q, size_d;
    logic [IMG_WIDTH*TIME_STEPS-1:0] line_q, line_d;
    logic                            done_q, done_d;
    logic [15:0]                     beat_limit;
    logic [TIME_STEPS-1:0]           mux_spikes;

    assign beat_limit = pix_q + 16'(2 * PAD);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pix_d   = pix_q;
        size_d  = size_q;
        line_d  = line_q;
        done_d  = 1'b0;

        if (bus.code_valid)
            size_d = bus.conv_img_size;

        case (state_q)
            IDLE: begin
                // The stored size is frozen into pix_q here; later size
                // updates only affect the next line.
                if (bus.i_line_data_valid) begin
                    line_d  = bus.i_line_data;
                    beat_d  = '0;
                    pix_d   = clamp_pixels(size_q, IMG_WIDTH);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.i_spikes_out_ready) begin
                    if (beat_q == (beat_limit - 16'd1)) begin
                        beat_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values; the line buffer is cleared on reset too
    // so a stale line can never leak out after reset.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            pix_q   <= '0;
            size_q  <= '0;
            line_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pix_q   <= pix_d;
            size_q  <= size_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    spike_pixel_mux #(
        .TIME_STEPS (TIME_STEPS),
        .IMG_WIDTH  (IMG_WIDTH),
        .PAD        (PAD)
    ) u_pixel_mux (
        .line_data (line_q),
        .beat_idx  (beat_q),
        .pix_count (pix_q),
        .spikes    (mux_spikes)
    );

    assign bus.o_line_ready       = (state_q == IDLE);
    assign bus.o_spikes_out_valid = (state_q == SEND);
    assign bus.o_spikes_out       = (state_q == SEND) ? mux_spikes : '0;
    assign bus.o_line_done        = done_q;

endmodule

// File: tb/tb_spike_line_serializer.sv
// Randomized bench for spike_line_serializer: a PAD=0 and a PAD=1 instance
// share stimulus and are checked beat by beat against a queue-based model.
module tb_spike_line_serializer;

    localparam int TS = 4;
    localparam int W  = 32;
    localparam int LW = TS * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          code_valid = 1'b0;
    logic [15:0]   conv = '0;
    logic [LW-1:0] line_data = '0;
    logic          line_valid = 1'b0;
    logic          rdy = 1'b1;
    int            mode = 0;

    int n_checks = 0;
    int n_errors = 0;

    logic [TS-1:0] exp_q [2][$];
    logic [TS-1:0] custom_q [$];
    bit            done_due [2];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spike_line_serializer_if #(.TIME_STEPS(TS), .IMG_WIDTH(W)) bus ();

        assign bus.code_valid         = code_valid;
        assign bus.conv_img_size      = conv;
        assign bus.i_line_data        = line_data;
        assign bus.i_line_data_valid  = line_valid;
        assign bus.i_spikes_out_ready = rdy;

        spike_line_serializer #(.TIME_STEPS(TS), .IMG_WIDTH(W), .PAD(g)) dut (
            .s_clk (clk),
            .s_rst (rst),
            .bus   (bus)
        );

        // Inputs change just after posedge, so negedge sees a settled cycle.
        always @(negedge clk) begin
            check($sformatf("pad%0d_done", g), 128'(bus.o_line_done), 128'(rst ? 1'b0 : done_due[g]));
            if (rst) begin
                done_due[g] = 1'b0;
                check($sformatf("pad%0d_rst_valid", g), 128'(bus.o_spikes_out_valid), 128'(0));
                check($sformatf("pad%0d_rst_spikes", g), 128'(bus.o_spikes_out), 128'(0));
            end else if (exp_q[g].size() == 0) begin
                done_due[g] = 1'b0;
                check($sformatf("pad%0d_idle_valid", g), 128'(bus.o_spikes_out_valid), 128'(0));
                check($sformatf("pad%0d_idle_ready", g), 128'(bus.o_line_ready), 128'(1));
                check($sformatf("pad%0d_idle_spikes", g), 128'(bus.o_spikes_out), 128'(0));
            end else begin
                check($sformatf("pad%0d_valid", g), 128'(bus.o_spikes_out_valid), 128'(1));
                check($sformatf("pad%0d_ready", g), 128'(bus.o_line_ready), 128'(0));
                check($sformatf("pad%0d_beat", g), 128'(bus.o_spikes_out), 128'(exp_q[g][0]));
                if (rdy) begin
                    void'(exp_q[g].pop_front());
                    done_due[g] = (exp_q[g].size() == 0);
                end else begin
                    done_due[g] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ~rdy;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Expected beats straight from the line-format rules.
    task automatic build(input int pad, input logic [15:0] size, input logic [LW-1:0] data);
        int p;
        if (size < 3)            p = 1;
        else if (size - 2 > W)   p = W;
        else                     p = int'(size) - 2;
        for (int b = 0; b < p + 2 * pad; b++) begin
            if (b < pad || b >= p + pad) exp_q[pad].push_back('0);
            else                         exp_q[pad].push_back(data[(b - pad) * TS +: TS]);
        end
    endtask

    task automatic load_line(input logic [15:0] size, input logic [LW-1:0] data,
                             input bit junk, input bit custom);
        code_valid = 1'b1;
        conv       = size;
        tick();
        code_valid = 1'b0;
        line_data  = data;
        line_valid = 1'b1;
        tick();
        line_valid = 1'b0;
        if (custom) exp_q[0] = custom_q;
        else        build(0, size, data);
        build(1, size, data);
        if (junk) begin
            // Both instances are mid-line here: this word and size must not
            // disturb the current line.
            line_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            line_valid = 1'b1;
            code_valid = 1'b1;
            conv       = 16'($urandom_range(0, 200));
            tick();
            line_valid = 1'b0;
            code_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int budget = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && budget < 400) begin
            tick();
            budget++;
        end
        if (budget >= 400) begin
            check("line_timeout", 128'(exp_q[0].size() + exp_q[1].size()), 128'(0));
            exp_q[0].delete();
            exp_q[1].delete();
        end
        tick();
    endtask

    task automatic send_line(input logic [15:0] size, input logic [LW-1:0] data, input bit junk);
        load_line(size, data, junk, 1'b0);
        wait_idle();
    endtask

    initial begin
        logic [LW-1:0] ramp;
        logic [LW-1:0] word;
        logic [TS-1:0] pix;

        for (int k = 0; k < W; k++) ramp[k*TS +: TS] = TS'(k);

        tick();
        tick();
        rst = 1'b0;
        tick();

        mode = 0; send_line(16'd34, ramp, 1'b0);
        mode = 1; send_line(16'd34, ramp, 1'b0);
        mode = 0; send_line(16'd10, ramp, 1'b0);
        send_line(16'd2, ramp, 1'b1);
        send_line(16'd100, ramp, 1'b1);

        // Reset in the middle of a line: the line is abandoned silently.
        load_line(16'd34, ramp, 1'b0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        send_line(16'd34, ramp, 1'b0);

        // Loopback: pack random pixels as the packer would, expect them back.
        for (int rep = 0; rep < 3; rep++) begin
            custom_q.delete();
            word = '0;
            for (int k = 0; k < W; k++) begin
                pix = TS'($urandom());
                word[k*TS +: TS] = pix;
                custom_q.push_back(pix);
            end
            mode = 2;
            load_line(16'd34, word, 1'b0, 1'b1);
            wait_idle();
        end

        mode = 2;
        for (int n = 0; n < 25; n++) begin
            word = {$urandom(), $urandom(), $urandom(), $urandom()};
            send_line(16'($urandom_range(0, 40)), word, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
